// File: rtl/uart_param_framer.sv
// Byte-stream frame parser: hunts for a start byte, collects PARAM_BYTES payload bytes MSB-first,
// verifies an 8-bit two's-complement checksum and offers the block on a valid/ready handshake.
module uart_param_framer #(
  parameter int unsigned PARAM_BYTES    = 26,
  parameter logic [7:0]  START_BYTE     = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic [8*PARAM_BYTES-1:0] params,
  output logic                     params_valid,
  input  logic                     params_ready,
  output logic                     frame_error,
  output logic [1:0]               error_code,
  output logic                     busy
);

  localparam int unsigned IdxW = (PARAM_BYTES > 1) ? $clog2(PARAM_BYTES) : 1;
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(PARAM_BYTES - 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ErrChecksum = 2'd1;
  localparam logic [1:0] ErrTimeout  = 2'd2;
  localparam logic [1:0] ErrOverrun  = 2'd3;

  typedef enum logic [1:0] {StHunt, StPayload, StCheck, StHold} state_e;

  state_e                   state_q;
  logic [IdxW-1:0]          idx_q;
  logic [TmoW-1:0]          tmo_q;
  logic [7:0]               sum_q;
  logic [8*PARAM_BYTES-1:0] shadow_q;
  logic [8*PARAM_BYTES-1:0] params_q;
  logic                     valid_q;
  logic                     err_q;
  logic [1:0]               code_q;

  logic       is_start;
  logic [7:0] sum_chk;
  logic       tmo_hit;

  assign is_start = rx_valid && (rx_data == START_BYTE);
  assign sum_chk  = sum_q + rx_data;
  // A byte in the expiry cycle takes priority, so expiry only counts on an idle cycle.
  assign tmo_hit  = !rx_valid && (tmo_q == TmoLast);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StHunt;
      idx_q    <= '0;
      tmo_q    <= '0;
      sum_q    <= '0;
      shadow_q <= '0;
      params_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= 2'd0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        StHunt: begin
          if (is_start) begin
            state_q <= StPayload;
            idx_q   <= LastIdx;
            sum_q   <= '0;
            tmo_q   <= '0;
          end
        end
        StPayload: begin
          if (rx_valid) begin
            shadow_q[8*idx_q +: 8] <= rx_data;
            sum_q                  <= sum_chk;
            tmo_q                  <= '0;
            if (idx_q == '0) begin
              state_q <= StCheck;
            end else begin
              idx_q <= idx_q - 1'b1;
            end
          end else if (tmo_hit) begin
            err_q   <= 1'b1;
            code_q  <= ErrTimeout;
            state_q <= StHunt;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        StCheck: begin
          if (rx_valid) begin
            tmo_q <= '0;
            if (sum_chk == 8'h00) begin
              params_q <= shadow_q;
              valid_q  <= 1'b1;
              state_q  <= StHold;
            end else begin
              err_q   <= 1'b1;
              code_q  <= ErrChecksum;
              state_q <= StHunt;
            end
          end else if (tmo_hit) begin
            err_q   <= 1'b1;
            code_q  <= ErrTimeout;
            state_q <= StHunt;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        StHold: begin
          if (params_ready) begin
            // Handshake completes; a coincident byte is judged as if already hunting.
            valid_q <= 1'b0;
            if (is_start) begin
              state_q <= StPayload;
              idx_q   <= LastIdx;
              sum_q   <= '0;
              tmo_q   <= '0;
            end else begin
              state_q <= StHunt;
            end
          end else if (rx_valid) begin
            err_q  <= 1'b1;
            code_q <= ErrOverrun;
          end
        end
      endcase
    end
  end

  assign params       = params_q;
  assign params_valid = valid_q;
  assign frame_error  = err_q;
  assign error_code   = code_q;
  assign busy         = (state_q == StPayload) || (state_q == StCheck);

endmodule

// File: tb/tb_uart_param_framer.sv
// Self-checking bench for uart_param_framer: table of frames plus hand sequences for timeout,
// overrun, embedded delimiter and reset; a scoreboard checks every output event.
module tb_uart_param_framer;

  localparam int unsigned PB  = 26;
  localparam int unsigned W   = 8 * PB;
  localparam int unsigned TMO = 50;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic [W-1:0] params;
  logic         params_valid;
  logic         params_ready;
  logic         frame_error;
  logic [1:0]   error_code;
  logic         busy;

  uart_param_framer #(
    .PARAM_BYTES   (PB),
    .START_BYTE    (8'hA5),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .params      (params),
    .params_valid(params_valid),
    .params_ready(params_ready),
    .frame_error (frame_error),
    .error_code  (error_code),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         is_err;
    logic [1:0]   code;
    logic [W-1:0] params;
  } exp_t;

  typedef struct {
    logic [7:0] base;
    logic [7:0] step;
    logic [7:0] adj;
    int         gap;
    logic [1:0] exp_code;
  } vec_t;

  exp_t         sb[$];
  vec_t         vecs[9];
  int           nvec = 0;
  int           nerr = 0;
  logic [W-1:0] model_params;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  function automatic logic [W-1:0] make_pay(input logic [7:0] base, input logic [7:0] step);
    logic [W-1:0] p;
    p = '0;
    for (int i = 0; i < PB; i++) p[W-1-8*i -: 8] = base + step * 8'(i);
    return p;
  endfunction

  function automatic logic [7:0] cks_of(input logic [W-1:0] p);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < PB; i++) s = s + p[8*i +: 8];
    return 8'h00 - s;
  endfunction

  task automatic push_good(input logic [W-1:0] p);
    sb.push_back('{1'b0, 2'd0, p});
    model_params = p;
  endtask

  task automatic push_err(input logic [1:0] code);
    sb.push_back('{1'b1, code, model_params});
  endtask

  task automatic send_payload(input logic [W-1:0] pay);
    for (int i = 0; i < PB; i++) send_byte(pay[W-1-8*i -: 8]);
  endtask

  task automatic send_frame(input logic [W-1:0] pay, input logic [7:0] cks, input int gap);
    send_byte(8'hA5);
    chk("busy_after_start", busy, 1'b1);
    send_payload(pay);
    if (gap > 0) idle(gap);
    chk("valid_before_cks", params_valid, 1'b0);
    send_byte(cks);
  endtask

  task automatic ack;
    idle(2);
    chk("valid_held", params_valid, 1'b1);
    params_ready = 1'b1;
    @(posedge clk);
    #1;
    params_ready = 1'b0;
    chk("valid_clears", params_valid, 1'b0);
  endtask

  // Scoreboard consumer: every new payload or error strobe must match the queue head.
  initial begin : monitor
    logic prev_valid;
    exp_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_valid = 1'b0;
      end else begin
        if ((params_valid && !prev_valid) || frame_error) begin
          if (sb.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL unexpected_event: got valid=%0b err=%0b code=%0d, want no event",
                     params_valid, frame_error, error_code);
          end else begin
            e = sb.pop_front();
            chk("event_kind", frame_error, e.is_err);
            if (e.is_err) chk("error_code", error_code, e.code);
            chk("params_at_event", params, e.params);
          end
        end
        prev_valid = params_valid;
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got no finish, want finish within time limit");
    $fatal(1);
  end

  initial begin : main
    logic [W-1:0] pay;
    logic [7:0]   cks;

    reset        = 1'b1;
    rx_valid     = 1'b0;
    rx_data      = 8'h00;
    params_ready = 1'b0;
    model_params = '0;

    //          base   step   adj    gap  code
    vecs[0] = '{8'h01, 8'h01, 8'h00, 0,   2'd0};
    vecs[1] = '{8'h01, 8'h01, 8'h3F, 0,   2'd1};  // checksum E0: bad
    vecs[2] = '{8'h00, 8'h00, 8'h00, 3,   2'd0};
    vecs[3] = '{8'hFF, 8'h00, 8'h00, 0,   2'd0};
    vecs[4] = '{8'hA5, 8'h03, 8'h00, 1,   2'd0};
    vecs[5] = '{8'h10, 8'h07, 8'h80, 0,   2'd1};
    vecs[6] = '{8'h01, 8'h01, 8'h00, 49,  2'd0};  // checksum lands in expiry cycle
    vecs[7] = '{8'h5A, 8'h11, 8'h00, 50,  2'd2};  // one idle cycle too many
    vecs[8] = '{8'h5A, 8'h11, 8'h00, 0,   2'd0};

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_params", params, '0);
    chk("reset_valid", params_valid, 1'b0);
    chk("reset_error", frame_error, 1'b0);
    chk("reset_code", error_code, 2'd0);
    chk("reset_busy", busy, 1'b0);
    idle(2);

    for (int i = 0; i < 9; i++) begin
      pay = make_pay(vecs[i].base, vecs[i].step);
      cks = cks_of(pay) + vecs[i].adj;
      if (vecs[i].exp_code == 2'd0) push_good(pay);
      else push_err(vecs[i].exp_code);
      send_frame(pay, cks, vecs[i].gap);
      if (vecs[i].exp_code == 2'd0) begin
        chk("valid_after_cks", params_valid, 1'b1);
        if (i == 0) begin
          chk("first_byte", params[W-1 -: 8], 8'h01);
          chk("last_byte", params[7:0], 8'h1A);
        end
        ack();
      end else begin
        chk("no_valid_on_error", params_valid, 1'b0);
      end
      idle(3);
    end

    // Timeout at exact cycle after a partial frame.
    push_err(2'd2);
    send_byte(8'hA5);
    for (int i = 0; i < 10; i++) send_byte(8'(8'h40 + i));
    idle(TMO - 1);
    chk("tmo_not_early", frame_error, 1'b0);
    idle(1);
    chk("tmo_strobe", frame_error, 1'b1);
    chk("tmo_code", error_code, 2'd2);
    chk("tmo_busy_low", busy, 1'b0);
    idle(3);

    // Noise before the delimiter and an embedded delimiter at index 10.
    send_byte(8'h00);
    send_byte(8'h7F);
    chk("noise_ignored", busy, 1'b0);
    pay = make_pay(8'h20, 8'h01);
    pay[87:80] = 8'hA5;
    push_good(pay);
    send_frame(pay, cks_of(pay), 0);
    chk("embedded_valid", params_valid, 1'b1);
    chk("embedded_a5", params[87:80], 8'hA5);
    ack();
    idle(2);

    // Overrun in HOLD, then a start byte coincident with the handshake.
    pay = make_pay(8'h30, 8'h05);
    push_good(pay);
    send_frame(pay, cks_of(pay), 0);
    push_err(2'd3);
    send_byte(8'h33);
    chk("overrun_valid_held", params_valid, 1'b1);
    chk("overrun_params", params, pay);
    pay = make_pay(8'h77, 8'h09);
    params_ready = 1'b1;
    rx_data      = 8'hA5;
    rx_valid     = 1'b1;
    @(posedge clk);
    #1;
    rx_valid     = 1'b0;
    params_ready = 1'b0;
    chk("simul_valid_clear", params_valid, 1'b0);
    chk("simul_busy", busy, 1'b1);
    push_good(pay);
    send_payload(pay);
    send_byte(cks_of(pay));
    chk("simul_frame_valid", params_valid, 1'b1);
    ack();
    idle(2);

    // Reset after five payload bytes aborts silently.
    send_byte(8'hA5);
    for (int i = 0; i < 5; i++) send_byte(8'(8'h60 + i));
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_params = '0;
    chk("rst_mid_params", params, '0);
    chk("rst_mid_valid", params_valid, 1'b0);
    chk("rst_mid_code", error_code, 2'd0);
    chk("rst_mid_busy", busy, 1'b0);
    idle(3);
    chk("rst_mid_no_err", frame_error, 1'b0);
    pay = make_pay(8'hC3, 8'h0D);
    push_good(pay);
    send_frame(pay, cks_of(pay), 0);
    chk("post_reset_valid", params_valid, 1'b1);
    ack();

    idle(3);
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
